// File: rtl/alu_pkg.sv
// Shared definitions for the ALU slice: operation encodings, ROB position
// width, data width and boolean constants, plus small opcode classifiers.
package alu_pkg;

    localparam int DATA_W    = 32;
    localparam int ROB_POS_W = 4;

    localparam logic [ROB_POS_W-1:0] ZERO_ROB = '0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [5:0] {
        OPENUM_NOP,
        OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
        OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
        OPENUM_LB, OPENUM_LH, OPENUM_LW, OPENUM_LBU, OPENUM_LHU,
        OPENUM_SB, OPENUM_SH, OPENUM_SW,
        OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI, OPENUM_ANDI,
        OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
        OPENUM_ADD, OPENUM_SUB, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU,
        OPENUM_XOR, OPENUM_SRL, OPENUM_SRA, OPENUM_OR, OPENUM_AND
    } openum_t;

    // Conditional branches: the only ops that feed the comparator.
    function automatic logic is_branch(openum_t op);
        case (op)
            OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT,
            OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU: is_branch = TRUE;
            default:                              is_branch = FALSE;
        endcase
    endfunction

    // Loads and stores belong to the memory unit; this ALU never answers them.
    function automatic logic is_mem(openum_t op);
        case (op)
            OPENUM_LB, OPENUM_LH, OPENUM_LW, OPENUM_LBU, OPENUM_LHU,
            OPENUM_SB, OPENUM_SH, OPENUM_SW: is_mem = TRUE;
            default:                         is_mem = FALSE;
        endcase
    endfunction

endpackage

// File: rtl/alu_branch_cmp.sv
// Combinational branch condition evaluator: decides whether a conditional
// branch is taken from its two source operands.
module alu_branch_cmp
    import alu_pkg::*;
(
    input  openum_t           op,
    input  logic [DATA_W-1:0] value1,
    input  logic [DATA_W-1:0] value2,
    output logic              taken
);

    logic signed [DATA_W-1:0] value1_s;
    logic signed [DATA_W-1:0] value2_s;

    assign value1_s = value1;
    assign value2_s = value2;

    // Signed compares use the signed views, unsigned ones the raw vectors.
    always_comb begin
        taken = FALSE;
        case (op)
            OPENUM_BEQ:  taken = (value1 == value2);
            OPENUM_BNE:  taken = (value1 != value2);
            OPENUM_BLT:  taken = (value1_s <  value2_s);
            OPENUM_BGE:  taken = (value1_s >= value2_s);
            OPENUM_BLTU: taken = (value1 <  value2);
            OPENUM_BGEU: taken = (value1 >= value2);
            default:     taken = FALSE;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Single-cycle integer ALU fed by a reservation station, broadcasting on the
// CDB one cycle after issue. Define ALU_BRANCH_STAT_EN to add branch/taken
// statistics counters.
module alu
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  openum_t              in_rs_op,
    input  logic [DATA_W-1:0]    in_rs_value1,
    input  logic [DATA_W-1:0]    in_rs_value2,
    input  logic [DATA_W-1:0]    in_rs_imm,
    input  logic [DATA_W-1:0]    in_rs_pc,
    input  logic [ROB_POS_W-1:0] in_rs_rob_pos,
    input  logic                 in_rob_xbp,
    output logic [ROB_POS_W-1:0] out_cdb_pos,
    output logic [DATA_W-1:0]    out_cdb_value,
    output logic                 out_cdb_jump,
`ifdef ALU_BRANCH_STAT_EN
    output logic [31:0]          out_stat_branch_cnt,
    output logic [31:0]          out_stat_taken_cnt,
`endif
    output logic [DATA_W-1:0]    out_cdb_target_pc
);

    logic signed [DATA_W-1:0] value1_s;
    logic signed [DATA_W-1:0] value2_s;
    logic signed [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0]        pc_plus4;
    logic [DATA_W-1:0]        pc_plus_imm;
    logic [DATA_W-1:0]        jalr_sum;
    logic [4:0]               shamt_r;
    logic [4:0]               shamt_i;

    logic                     vld_p0;
    logic                     taken_p0;
    logic [DATA_W-1:0]        res_p0;
    logic                     jump_p0;
    logic [DATA_W-1:0]        target_p0;

    assign value1_s    = in_rs_value1;
    assign value2_s    = in_rs_value2;
    assign imm_s       = in_rs_imm;
    assign pc_plus4    = in_rs_pc + 32'd4;
    assign pc_plus_imm = in_rs_pc + in_rs_imm;
    assign jalr_sum    = in_rs_value1 + in_rs_imm;
    assign shamt_r     = in_rs_value2[4:0];
    assign shamt_i     = in_rs_imm[4:0];

    // Stage p0: decode issue validity and evaluate the operation.
    assign vld_p0 = !in_rob_xbp
                 && (in_rs_op != OPENUM_NOP)
                 && (in_rs_rob_pos != ZERO_ROB)
                 && !is_mem(in_rs_op);

    alu_branch_cmp u_branch_cmp (
        .op     (in_rs_op),
        .value1 (in_rs_value1),
        .value2 (in_rs_value2),
        .taken  (taken_p0)
    );

    // Result, jump flag and next PC for whatever op is presented this cycle.
    always_comb begin
        res_p0    = '0;
        jump_p0   = FALSE;
        target_p0 = pc_plus4;
        case (in_rs_op)
            OPENUM_ADD:   res_p0 = in_rs_value1 + in_rs_value2;
            OPENUM_SUB:   res_p0 = in_rs_value1 - in_rs_value2;
            OPENUM_SLL:   res_p0 = in_rs_value1 << shamt_r;
            OPENUM_SRL:   res_p0 = in_rs_value1 >> shamt_r;
            OPENUM_SRA:   res_p0 = value1_s >>> shamt_r;
            OPENUM_SLT:   res_p0 = {{(DATA_W-1){1'b0}}, (value1_s < value2_s)};
            OPENUM_SLTU:  res_p0 = {{(DATA_W-1){1'b0}}, (in_rs_value1 < in_rs_value2)};
            OPENUM_XOR:   res_p0 = in_rs_value1 ^ in_rs_value2;
            OPENUM_OR:    res_p0 = in_rs_value1 | in_rs_value2;
            OPENUM_AND:   res_p0 = in_rs_value1 & in_rs_value2;
            OPENUM_ADDI:  res_p0 = in_rs_value1 + in_rs_imm;
            OPENUM_SLTI:  res_p0 = {{(DATA_W-1){1'b0}}, (value1_s < imm_s)};
            OPENUM_SLTIU: res_p0 = {{(DATA_W-1){1'b0}}, (in_rs_value1 < in_rs_imm)};
            OPENUM_XORI:  res_p0 = in_rs_value1 ^ in_rs_imm;
            OPENUM_ORI:   res_p0 = in_rs_value1 | in_rs_imm;
            OPENUM_ANDI:  res_p0 = in_rs_value1 & in_rs_imm;
            OPENUM_SLLI:  res_p0 = in_rs_value1 << shamt_i;
            OPENUM_SRLI:  res_p0 = in_rs_value1 >> shamt_i;
            OPENUM_SRAI:  res_p0 = value1_s >>> shamt_i;
            OPENUM_LUI:   res_p0 = in_rs_imm;
            OPENUM_AUIPC: res_p0 = pc_plus_imm;
            OPENUM_JAL: begin
                res_p0    = pc_plus4;
                jump_p0   = TRUE;
                target_p0 = pc_plus_imm;
            end
            OPENUM_JALR: begin
                res_p0    = pc_plus4;
                jump_p0   = TRUE;
                target_p0 = {jalr_sum[DATA_W-1:1], 1'b0};
            end
            OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT,
            OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU: begin
                res_p0    = '0;
                jump_p0   = taken_p0;
                target_p0 = taken_p0 ? pc_plus_imm : pc_plus4;
            end
            default: begin
                res_p0    = '0;
                jump_p0   = FALSE;
                target_p0 = pc_plus4;
            end
        endcase
    end

    // Stage p1: CDB broadcast register; one-cycle pulse per accepted issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cdb_pos       <= ZERO_ROB;
            out_cdb_value     <= '0;
            out_cdb_jump      <= FALSE;
            out_cdb_target_pc <= '0;
        end else if (rdy) begin
            if (vld_p0) begin
                out_cdb_pos       <= in_rs_rob_pos;
                out_cdb_value     <= res_p0;
                out_cdb_jump      <= jump_p0;
                out_cdb_target_pc <= target_p0;
            end else begin
                out_cdb_pos  <= ZERO_ROB;
                out_cdb_jump <= FALSE;
            end
        end
    end

`ifdef ALU_BRANCH_STAT_EN
    // Count accepted branches and taken ones; a flush does not rewind them.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_stat_branch_cnt <= '0;
            out_stat_taken_cnt  <= '0;
        end else if (rdy && vld_p0 && is_branch(in_rs_op)) begin
            out_stat_branch_cnt <= out_stat_branch_cnt + 32'd1;
            if (taken_p0) begin
                out_stat_taken_cnt <= out_stat_taken_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Directed testbench for the ALU: hand-computed vectors, inline checks.
module tb_alu;
    import alu_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rdy;
    openum_t              in_rs_op;
    logic [DATA_W-1:0]    in_rs_value1;
    logic [DATA_W-1:0]    in_rs_value2;
    logic [DATA_W-1:0]    in_rs_imm;
    logic [DATA_W-1:0]    in_rs_pc;
    logic [ROB_POS_W-1:0] in_rs_rob_pos;
    logic                 in_rob_xbp;
    logic [ROB_POS_W-1:0] out_cdb_pos;
    logic [DATA_W-1:0]    out_cdb_value;
    logic                 out_cdb_jump;
    logic [DATA_W-1:0]    out_cdb_target_pc;
`ifdef ALU_BRANCH_STAT_EN
    logic [31:0]          out_stat_branch_cnt;
    logic [31:0]          out_stat_taken_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .in_rs_op          (in_rs_op),
        .in_rs_value1      (in_rs_value1),
        .in_rs_value2      (in_rs_value2),
        .in_rs_imm         (in_rs_imm),
        .in_rs_pc          (in_rs_pc),
        .in_rs_rob_pos     (in_rs_rob_pos),
        .in_rob_xbp        (in_rob_xbp),
        .out_cdb_pos       (out_cdb_pos),
        .out_cdb_value     (out_cdb_value),
        .out_cdb_jump      (out_cdb_jump),
`ifdef ALU_BRANCH_STAT_EN
        .out_stat_branch_cnt (out_stat_branch_cnt),
        .out_stat_taken_cnt  (out_stat_taken_cnt),
`endif
        .out_cdb_target_pc (out_cdb_target_pc)
    );

    always #5 clk = ~clk;

    task automatic drive(input openum_t op, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] pos);
        in_rs_op      = op;
        in_rs_value1  = v1;
        in_rs_value2  = v2;
        in_rs_imm     = imm;
        in_rs_pc      = pc;
        in_rs_rob_pos = pos;
    endtask

    task automatic idle();
        drive(OPENUM_NOP, 32'h0, 32'h0, 32'h0, 32'h0, ZERO_ROB);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; in_rob_xbp = 1'b0;
        drive(OPENUM_ADD, 32'h5, 32'h6, 32'h0, 32'h10, 4'd7);
        step(); step();
        n_checks++; if (out_cdb_pos !== ZERO_ROB) begin n_fail++; $display("FAIL reset_pos: got %0d want 0", out_cdb_pos); end
        n_checks++; if (out_cdb_value !== 32'h0) begin n_fail++; $display("FAIL reset_value: got %h want 0", out_cdb_value); end
        n_checks++; if (out_cdb_jump !== 1'b0) begin n_fail++; $display("FAIL reset_jump: got %b want 0", out_cdb_jump); end
        n_checks++; if (out_cdb_target_pc !== 32'h0) begin n_fail++; $display("FAIL reset_target: got %h want 0", out_cdb_target_pc); end
`ifdef ALU_BRANCH_STAT_EN
        n_checks++; if (out_stat_branch_cnt !== 32'd0 || out_stat_taken_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stat: got %0d/%0d want 0/0", out_stat_branch_cnt, out_stat_taken_cnt); end
`endif
        rst = 1'b0;
        // Produce a non-zero result, then reset with rdy low: reset must win.
        drive(OPENUM_JAL, 32'h0, 32'h0, 32'h100, 32'h40, 4'd9);
        step();
        n_checks++; if (out_cdb_pos !== 4'd9) begin n_fail++; $display("FAIL pre_reset_pos: got %0d want 9", out_cdb_pos); end
        rst = 1'b1; rdy = 1'b0; in_rob_xbp = 1'b1;
        step();
        n_checks++; if (out_cdb_pos !== ZERO_ROB || out_cdb_value !== 32'h0 || out_cdb_jump !== 1'b0 || out_cdb_target_pc !== 32'h0)
            begin n_fail++; $display("FAIL reset_prio: got pos=%0d val=%h j=%b tgt=%h want 0/0/0/0", out_cdb_pos, out_cdb_value, out_cdb_jump, out_cdb_target_pc); end
        rst = 1'b0; rdy = 1'b1; in_rob_xbp = 1'b0;
        idle();
        step();
    endtask

    task automatic test_add_sub();
        drive(OPENUM_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h200, 4'd3);
        step();
        n_checks++; if (out_cdb_pos !== 4'd3) begin n_fail++; $display("FAIL add_pos: got %0d want 3", out_cdb_pos); end
        n_checks++; if (out_cdb_value !== 32'h8000_0000) begin n_fail++; $display("FAIL add_value: got %h want 80000000", out_cdb_value); end
        n_checks++; if (out_cdb_jump !== 1'b0) begin n_fail++; $display("FAIL add_jump: got %b want 0", out_cdb_jump); end
        n_checks++; if (out_cdb_target_pc !== 32'h204) begin n_fail++; $display("FAIL add_target: got %h want 204", out_cdb_target_pc); end
        idle();
        step();
        n_checks++; if (out_cdb_pos !== ZERO_ROB || out_cdb_jump !== 1'b0) begin n_fail++; $display("FAIL add_one_shot: got pos=%0d j=%b want 0/0", out_cdb_pos, out_cdb_jump); end
        drive(OPENUM_SUB, 32'h0, 32'h1, 32'h0, 32'h0, 4'd4);
        step();
        n_checks++; if (out_cdb_value !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub_wrap: got %h want ffffffff", out_cdb_value); end
        drive(OPENUM_ADDI, 32'hFFFF_FFFF, 32'h0, 32'h2, 32'h0, 4'd4);
        step();
        n_checks++; if (out_cdb_value !== 32'h1) begin n_fail++; $display("FAIL addi_wrap: got %h want 1", out_cdb_value); end
        drive(OPENUM_XORI, 32'hF0F0_F0F0, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'd4);
        step();
        n_checks++; if (out_cdb_value !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL xori: got %h want 0f0f0f0f", out_cdb_value); end
        idle();
    endtask

    task automatic test_shift();
        drive(OPENUM_SRAI, 32'h8000_0000, 32'h0, 32'h21, 32'h0, 4'd1);
        step();
        n_checks++; if (out_cdb_value !== 32'hC000_0000) begin n_fail++; $display("FAIL srai: got %h want c0000000", out_cdb_value); end
        drive(OPENUM_SRL, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 4'd1);
        step();
        n_checks++; if (out_cdb_value !== 32'h4000_0000) begin n_fail++; $display("FAIL srl: got %h want 40000000", out_cdb_value); end
        drive(OPENUM_SLL, 32'h1, 32'h3F, 32'h0, 32'h0, 4'd1);
        step();
        n_checks++; if (out_cdb_value !== 32'h8000_0000) begin n_fail++; $display("FAIL sll: got %h want 80000000", out_cdb_value); end
        drive(OPENUM_SRA, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 4'd1);
        step();
        n_checks++; if (out_cdb_value !== 32'hF800_0000) begin n_fail++; $display("FAIL sra: got %h want f8000000", out_cdb_value); end
        idle();
    endtask

    task automatic test_compare();
        drive(OPENUM_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 4'd2);
        step();
        n_checks++; if (out_cdb_value !== 32'h1) begin n_fail++; $display("FAIL slt: got %h want 1", out_cdb_value); end
        drive(OPENUM_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 4'd2);
        step();
        n_checks++; if (out_cdb_value !== 32'h0) begin n_fail++; $display("FAIL sltu: got %h want 0", out_cdb_value); end
        drive(OPENUM_SLTIU, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'd2);
        step();
        n_checks++; if (out_cdb_value !== 32'h1) begin n_fail++; $display("FAIL sltiu: got %h want 1", out_cdb_value); end
        drive(OPENUM_SLTI, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'd2);
        step();
        n_checks++; if (out_cdb_value !== 32'h0) begin n_fail++; $display("FAIL slti: got %h want 0", out_cdb_value); end
        idle();
    endtask

    task automatic test_upper_jump();
        drive(OPENUM_LUI, 32'h0, 32'h0, 32'h1234_5000, 32'h80, 4'd6);
        step();
        n_checks++; if (out_cdb_value !== 32'h1234_5000 || out_cdb_jump !== 1'b0) begin n_fail++; $display("FAIL lui: got %h j=%b want 12345000 j=0", out_cdb_value, out_cdb_jump); end
        drive(OPENUM_AUIPC, 32'h0, 32'h0, 32'h2000, 32'h1000, 4'd6);
        step();
        n_checks++; if (out_cdb_value !== 32'h3000 || out_cdb_target_pc !== 32'h1004) begin n_fail++; $display("FAIL auipc: got %h tgt=%h want 3000 tgt=1004", out_cdb_value, out_cdb_target_pc); end
        drive(OPENUM_JAL, 32'h0, 32'h0, 32'h100, 32'h40, 4'd6);
        step();
        n_checks++; if (out_cdb_value !== 32'h44 || out_cdb_target_pc !== 32'h140 || out_cdb_jump !== 1'b1)
            begin n_fail++; $display("FAIL jal: got %h tgt=%h j=%b want 44 tgt=140 j=1", out_cdb_value, out_cdb_target_pc, out_cdb_jump); end
        drive(OPENUM_JALR, 32'h1001, 32'h0, 32'h2, 32'h40, 4'd6);
        step();
        n_checks++; if (out_cdb_value !== 32'h44) begin n_fail++; $display("FAIL jalr_value: got %h want 44", out_cdb_value); end
        n_checks++; if (out_cdb_target_pc !== 32'h1002) begin n_fail++; $display("FAIL jalr_target: got %h want 1002", out_cdb_target_pc); end
        n_checks++; if (out_cdb_jump !== 1'b1) begin n_fail++; $display("FAIL jalr_jump: got %b want 1", out_cdb_jump); end
        idle();
    endtask

    task automatic test_branch();
        drive(OPENUM_BLT, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 4'd8);
        step();
        n_checks++; if (out_cdb_jump !== 1'b1 || out_cdb_target_pc !== 32'h120 || out_cdb_value !== 32'h0)
            begin n_fail++; $display("FAIL blt: got j=%b tgt=%h val=%h want 1/120/0", out_cdb_jump, out_cdb_target_pc, out_cdb_value); end
        drive(OPENUM_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 4'd8);
        step();
        n_checks++; if (out_cdb_jump !== 1'b0 || out_cdb_target_pc !== 32'h104)
            begin n_fail++; $display("FAIL bltu: got j=%b tgt=%h want 0/104", out_cdb_jump, out_cdb_target_pc); end
        drive(OPENUM_BEQ, 32'h55, 32'h55, 32'h8, 32'h300, 4'd8);
        step();
        n_checks++; if (out_cdb_jump !== 1'b1 || out_cdb_target_pc !== 32'h308) begin n_fail++; $display("FAIL beq: got j=%b tgt=%h want 1/308", out_cdb_jump, out_cdb_target_pc); end
        drive(OPENUM_BNE, 32'h55, 32'h55, 32'h8, 32'h300, 4'd8);
        step();
        n_checks++; if (out_cdb_jump !== 1'b0 || out_cdb_target_pc !== 32'h304) begin n_fail++; $display("FAIL bne: got j=%b tgt=%h want 0/304", out_cdb_jump, out_cdb_target_pc); end
        drive(OPENUM_BGE, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h300, 4'd8);
        step();
        n_checks++; if (out_cdb_jump !== 1'b1 || out_cdb_target_pc !== 32'h2F0) begin n_fail++; $display("FAIL bge: got j=%b tgt=%h want 1/2f0", out_cdb_jump, out_cdb_target_pc); end
        drive(OPENUM_BGEU, 32'h1, 32'hFFFF_FFFF, 32'h10, 32'h300, 4'd8);
        step();
        n_checks++; if (out_cdb_jump !== 1'b0 || out_cdb_target_pc !== 32'h304) begin n_fail++; $display("FAIL bgeu: got j=%b tgt=%h want 0/304", out_cdb_jump, out_cdb_target_pc); end
        idle();
    endtask

    task automatic test_no_issue();
        drive(OPENUM_LW, 32'h10, 32'h0, 32'h4, 32'h0, 4'd5);
        step();
        n_checks++; if (out_cdb_pos !== ZERO_ROB) begin n_fail++; $display("FAIL load_dropped: got pos=%0d want 0", out_cdb_pos); end
        drive(OPENUM_SW, 32'h10, 32'h1, 32'h4, 32'h0, 4'd5);
        step();
        n_checks++; if (out_cdb_pos !== ZERO_ROB) begin n_fail++; $display("FAIL store_dropped: got pos=%0d want 0", out_cdb_pos); end
        drive(OPENUM_ADD, 32'h1, 32'h1, 32'h0, 32'h0, ZERO_ROB);
        step();
        n_checks++; if (out_cdb_pos !== ZERO_ROB) begin n_fail++; $display("FAIL zero_rob_dropped: got pos=%0d want 0", out_cdb_pos); end
        drive(OPENUM_JAL, 32'h0, 32'h0, 32'h40, 32'h0, 4'd5);
        in_rob_xbp = 1'b1;
        step();
        n_checks++; if (out_cdb_pos !== ZERO_ROB || out_cdb_jump !== 1'b0) begin n_fail++; $display("FAIL xbp_flush: got pos=%0d j=%b want 0/0", out_cdb_pos, out_cdb_jump); end
        in_rob_xbp = 1'b0;
        idle();
    endtask

    task automatic test_stall();
        drive(OPENUM_ADD, 32'd10, 32'd20, 32'h0, 32'h80, 4'd5);
        step();
        n_checks++; if (out_cdb_pos !== 4'd5 || out_cdb_value !== 32'd30) begin n_fail++; $display("FAIL stall_setup: got pos=%0d val=%h want 5/1e", out_cdb_pos, out_cdb_value); end
        rdy = 1'b0;
        drive(OPENUM_SUB, 32'd50, 32'd8, 32'h0, 32'h90, 4'd6);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (out_cdb_pos !== 4'd5 || out_cdb_value !== 32'd30 || out_cdb_target_pc !== 32'h84 || out_cdb_jump !== 1'b0)
                begin n_fail++; $display("FAIL stall_hold[%0d]: got pos=%0d val=%h tgt=%h j=%b want 5/1e/84/0", i, out_cdb_pos, out_cdb_value, out_cdb_target_pc, out_cdb_jump); end
        end
        rdy = 1'b1;
        step();
        n_checks++; if (out_cdb_pos !== 4'd6 || out_cdb_value !== 32'd42 || out_cdb_target_pc !== 32'h94)
            begin n_fail++; $display("FAIL stall_represent: got pos=%0d val=%h tgt=%h want 6/2a/94", out_cdb_pos, out_cdb_value, out_cdb_target_pc); end
        idle();
    endtask

    task automatic test_back_to_back();
        drive(OPENUM_OR, 32'hF0, 32'h0F, 32'h0, 32'h0, 4'd1);
        step();
        n_checks++; if (out_cdb_pos !== 4'd1 || out_cdb_value !== 32'hFF) begin n_fail++; $display("FAIL b2b_first: got pos=%0d val=%h want 1/ff", out_cdb_pos, out_cdb_value); end
        drive(OPENUM_AND, 32'hF0, 32'h3C, 32'h0, 32'h0, 4'd2);
        step();
        n_checks++; if (out_cdb_pos !== 4'd2 || out_cdb_value !== 32'h30) begin n_fail++; $display("FAIL b2b_second: got pos=%0d val=%h want 2/30", out_cdb_pos, out_cdb_value); end
        idle();
        step();
        n_checks++; if (out_cdb_pos !== ZERO_ROB) begin n_fail++; $display("FAIL b2b_idle: got pos=%0d want 0", out_cdb_pos); end
    endtask

`ifdef ALU_BRANCH_STAT_EN
    task automatic test_stat();
        rst = 1'b1; idle(); step(); rst = 1'b0;
        drive(OPENUM_BEQ,  32'h5, 32'h5, 32'h8, 32'h0, 4'd1); step();
        drive(OPENUM_BNE,  32'h5, 32'h5, 32'h8, 32'h0, 4'd2); step();
        drive(OPENUM_BLT,  32'hFFFF_FFFF, 32'h1, 32'h8, 32'h0, 4'd3); step();
        drive(OPENUM_BGEU, 32'h1, 32'hFFFF_FFFF, 32'h8, 32'h0, 4'd4); step();
        // Flushed and stalled branches are not accepted, so not counted.
        in_rob_xbp = 1'b1;
        drive(OPENUM_BEQ,  32'h5, 32'h5, 32'h8, 32'h0, 4'd5); step();
        in_rob_xbp = 1'b0; rdy = 1'b0; step(); rdy = 1'b1;
        drive(OPENUM_BLTU, 32'h1, 32'h2, 32'h8, 32'h0, 4'd6); step();
        idle(); in_rob_xbp = 1'b1; step(); in_rob_xbp = 1'b0;
        n_checks++; if (out_stat_branch_cnt !== 32'd5) begin n_fail++; $display("FAIL stat_branch: got %0d want 5", out_stat_branch_cnt); end
        n_checks++; if (out_stat_taken_cnt !== 32'd3) begin n_fail++; $display("FAIL stat_taken: got %0d want 3", out_stat_taken_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; rdy = 1'b1; in_rob_xbp = 1'b0;
        idle();
        test_reset();
        test_add_sub();
        test_shift();
        test_compare();
        test_upper_jump();
        test_branch();
        test_no_issue();
        test_stall();
        test_back_to_back();
`ifdef ALU_BRANCH_STAT_EN
        test_stat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
